// File: rtl/fless_arbiter.sv
// Round-robin arbiter sharing one IEEE-754 single-precision "less than" comparator
// among NREQ requesters, with latched operands and a registered, id-tagged response.

module fless (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt
);

    logic a_nan;
    logic b_nan;
    logic both_zero;
    logic mag_lt;
    logic mag_gt;

    assign a_nan     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign b_nan     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    assign mag_lt    = a[30:0] < b[30:0];
    assign mag_gt    = a[30:0] > b[30:0];

    // Unordered operands and -0 vs +0 both compare false; otherwise sign-magnitude order.
    always_comb begin
        if (a_nan || b_nan || both_zero) begin
            lt = 1'b0;
        end else if (a[31] != b[31]) begin
            lt = a[31];
        end else if (a[31]) begin
            lt = mag_gt;
        end else begin
            lt = mag_lt;
        end
    end

endmodule

module fless_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_op1,
    input  logic [NREQ*32-1:0]   req_op2,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic                 resp_result,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        RESP
    } state_t;

    state_t          state;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] id_q;
    logic [31:0]     op1_q;
    logic [31:0]     op2_q;
    logic            cmp_lt;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand;

    // Search starts just after the last winner so every requester is reached within NREQ grants.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = ID_W'((int'(last) + off) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found) begin
            req_ready = NREQ'(1) << grant_idx;
        end
    end

    assign busy = (state != IDLE);

    fless u_fless (
        .a  (op1_q),
        .b  (op2_q),
        .lt (cmp_lt)
    );

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= ID_W'(NREQ - 1);
            id_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op1_q <= req_op1[32*grant_idx +: 32];
                        op2_q <= req_op2[32*grant_idx +: 32];
                        id_q  <= grant_idx;
                        last  <= grant_idx;
                        state <= CMP;
                    end
                end
                CMP: begin
                    resp_result <= cmp_lt;
                    resp_id     <= id_q;
                    resp_valid  <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
